// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch FSM state encoding (2 bits, legacy-compatible constants)
    localparam logic [1:0] S_REQ   = 2'd0;  // presenting a request to imem
    localparam logic [1:0] S_WAIT  = 2'd1;  // request accepted, awaiting response
    localparam logic [1:0] S_VALID = 2'd2;  // instruction held for decode
    localparam logic [1:0] S_DROP  = 2'd3;  // stale response in flight, discard it

    // addi x0,x0,0 -- driven to decode whenever nothing valid is held
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC  = 64'h0;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch control FSM: sequences the single-outstanding imem handshake and decode hand-off.
// Latency: registered state; all strobes are combinational from state and inputs.
// Backpressure: imem_ready stalls in S_REQ, StallF holds S_VALID, PCSrcE overrides both.
module fetch_fsm
    import fetch_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic StallF,
    input  logic PCSrcE,
    input  logic imem_ready,
    input  logic imem_rvalid,
    output logic imem_req,
    output logic instr_valid,
    output logic pc_load_target,
    output logic pc_incr,
    output logic buf_load,
    output logic buf_clear
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    // State register; reset abandons any transaction in progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; a redirect always wins over normal progress
    always_comb begin
        state_d        = state_q;
        imem_req       = 1'b0;
        instr_valid    = 1'b0;
        pc_load_target = 1'b0;
        pc_incr        = 1'b0;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (PCSrcE) begin
                    // A request accepted now fetches the old PC; its reply must be dropped
                    pc_load_target = 1'b1;
                    state_d        = imem_ready ? S_DROP : S_REQ;
                end else if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pc_load_target = 1'b1;
                    state_d        = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    buf_load = 1'b1;
                    state_d  = S_VALID;
                end
            end
            S_DROP: begin
                // Further redirects just retarget the PC; the stale reply is still owed
                pc_load_target = PCSrcE;
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (PCSrcE) begin
                    pc_load_target = 1'b1;
                    buf_clear      = 1'b1;
                    state_d        = S_REQ;
                end else if (!StallF) begin
                    pc_incr   = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Pipeline fetch stage: owns the PC, fetches one instruction at a time, holds it for decode.
// Latency: request -> response (>=1 cycle) -> InstrValidF next cycle; best case 1 instr / 3 cycles.
// Backpressure: StallF holds the buffered instruction; imem_ready low holds the request stable.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [63:0] PCTargetE,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [63:0] PCF,
    output logic [63:0] PCPlus4F,
    output logic        InstrValidF
);

    logic [63:0] pc_q;
    logic [31:0] buf_q;
    logic        instr_valid;
    logic        pc_load_target;
    logic        pc_incr;
    logic        buf_load;
    logic        buf_clear;

    fetch_fsm u_fsm (
        .clock          (clock),
        .reset          (reset),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_req       (imem_req),
        .instr_valid    (instr_valid),
        .pc_load_target (pc_load_target),
        .pc_incr        (pc_incr),
        .buf_load       (buf_load),
        .buf_clear      (buf_clear)
    );

    // Sequential PC wraps modulo 2^64 with no flag
    assign PCPlus4F = pc_q + 64'd4;

    // PC register: redirect targets are word-aligned on load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (pc_load_target) begin
            pc_q <= PCTargetE & ~64'h3;
        end else if (pc_incr) begin
            pc_q <= PCPlus4F;
        end
    end

    // Instruction buffer: captures the response, reverts to NOP once consumed or flushed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q <= NOP_INSTR;
        end else if (buf_load) begin
            buf_q <= imem_rdata;
        end else if (buf_clear) begin
            buf_q <= NOP_INSTR;
        end
    end

    assign imem_addr   = {pc_q[63:2], 2'b00};
    assign PCF         = pc_q;
    assign InstrValidF = instr_valid;
    assign InstrF      = instr_valid ? buf_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/100ps
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [63:0] PCTargetE = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrF;
    logic [63:0] PCF;
    logic [63:0] PCPlus4F;
    logic        InstrValidF;

    int checks = 0;
    int errors = 0;

    // memory model controls: ready_mode 0 = always ready, 1 = random, 2 = never
    int          ready_mode = 0;
    int          mem_lat = 1;
    bit          mem_rand_lat = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [63:0] mem_pend_addr = '0;

    // reference model state: next PC decode should receive
    logic [63:0] exp_pc = RST_PC;
    int          n_accept = 0;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clock       (clock),
        .reset       (reset),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h104) return 32'h00A0_0513;
        return {a[29:0], 2'b11} ^ 32'h3C5A_0000;
    endfunction

    // instruction memory: one outstanding request, response after a latency
    initial begin
        forever begin
            @(negedge clock);
            #0.5;
            if (!reset) begin
                mem_busy    = 1'b0;
                imem_rvalid = 1'b0;
                imem_ready  = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(mem_pend_addr);
                        mem_busy    = 1'b0;
                    end
                end
                case (ready_mode)
                    0:       imem_ready = 1'b1;
                    1:       imem_ready = 1'($urandom_range(0, 1));
                    default: imem_ready = 1'b0;
                endcase
                if (imem_req === 1'b1 && imem_ready) begin
                    checks++;
                    if (mem_busy) begin
                        errors++;
                        $display("FAIL mem_outstanding: request at %h while one pending, required none", imem_addr);
                    end
                    mem_busy      = 1'b1;
                    mem_pend_addr = imem_addr;
                    mem_cnt       = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                end
            end
        end
    end

    // reference model: every instruction decode accepts must be the next PC in program order
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset) begin
                exp_pc = RST_PC;
            end else begin
                checks++;
                if (InstrValidF) begin
                    if (InstrF !== mem_word(PCF) || PCPlus4F !== PCF + 64'd4) begin
                        errors++;
                        $display("FAIL mon_instr: PCF=%h InstrF=%h PCPlus4F=%h, required InstrF=%h PCPlus4F=%h",
                                 PCF, InstrF, PCPlus4F, mem_word(PCF), PCF + 64'd4);
                    end
                end else if (InstrF !== NOP) begin
                    errors++;
                    $display("FAIL mon_nop: InstrF=%h with InstrValidF=0, required %h", InstrF, NOP);
                end
                if (imem_rvalid && (imem_req || InstrValidF)) begin
                    errors++;
                    $display("FAIL mon_protocol: rvalid while req=%b valid=%b, required both 0", imem_req, InstrValidF);
                end
                if (imem_req && imem_addr !== {PCF[63:2], 2'b00}) begin
                    errors++;
                    $display("FAIL mon_addr: imem_addr=%h, required %h", imem_addr, {PCF[63:2], 2'b00});
                end
                if (PCSrcE) begin
                    exp_pc = PCTargetE & ~64'h3;
                end else if (InstrValidF && !StallF) begin
                    checks++;
                    if (PCF !== exp_pc) begin
                        errors++;
                        $display("FAIL mon_order: accepted PCF=%h, required %h", PCF, exp_pc);
                    end
                    exp_pc = exp_pc + 64'd4;
                    n_accept++;
                end
            end
        end
    end

    // all helper tasks are entered at a falling edge
    task automatic apply_reset();
        @(negedge clock);
        reset  = 1'b0;
        StallF = 1'b0;
        PCSrcE = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_hs(input int max, output bit ok, output logic [63:0] a);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < max; i++) begin
            #1;
            if (imem_req && imem_ready) begin
                ok = 1'b1;
                a  = imem_addr;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            #1;
            if (InstrValidF) begin
                ok = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        checks++;
        if (InstrValidF !== 1'b0 || PCF !== RST_PC || InstrF !== NOP || PCPlus4F !== RST_PC + 64'd4) begin
            errors++;
            $display("FAIL reset_state: valid=%b PCF=%h InstrF=%h PCPlus4F=%h, required 0 %h %h %h",
                     InstrValidF, PCF, InstrF, PCPlus4F, RST_PC, NOP, RST_PC + 64'd4);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] hs_addr[$];
        int          vcyc[$];
        logic [63:0] vpc[$];
        ready_mode = 0; mem_lat = 1; mem_rand_lat = 1'b0;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            #1;
            if (imem_req && imem_ready) hs_addr.push_back(imem_addr);
            if (InstrValidF) begin
                vcyc.push_back(c);
                vpc.push_back(PCF);
            end
            @(negedge clock);
        end
        checks++;
        if (hs_addr.size() < 3 || vcyc.size() < 3) begin
            errors++;
            $display("FAIL seq_count: %0d requests %0d valids, required >=3 each", hs_addr.size(), vcyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (hs_addr[k] !== RST_PC + 64'(4 * k) || vpc[k] !== RST_PC + 64'(4 * k)) begin
                    errors++;
                    $display("FAIL seq_addr%0d: addr=%h PCF=%h, required %h", k, hs_addr[k], vpc[k], RST_PC + 64'(4 * k));
                end
            end
            for (int k = 1; k < vcyc.size(); k++) begin
                checks++;
                if (vcyc[k] - vcyc[k-1] != 3) begin
                    errors++;
                    $display("FAIL seq_rate: valid gap %0d cycles, required 3", vcyc[k] - vcyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit          ok;
        logic [63:0] a;
        ready_mode = 0; mem_lat = 1; mem_rand_lat = 1'b0;
        apply_reset();
        StallF = 1'b1;
        wait_valid(10, ok);
        checks++;
        if (!ok || PCF !== 64'h100) begin
            errors++;
            $display("FAIL stall_first: ok=%b PCF=%h, required 1 %h", ok, PCF, 64'h100);
        end
        @(negedge clock) StallF = 1'b0;
        @(negedge clock) StallF = 1'b1;
        wait_valid(10, ok);
        checks++;
        if (!ok || PCF !== 64'h104) begin
            errors++;
            $display("FAIL stall_second: ok=%b PCF=%h, required 1 %h", ok, PCF, 64'h104);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (InstrF !== 32'h00A0_0513 || PCF !== 64'h104 || InstrValidF !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: InstrF=%h PCF=%h valid=%b req=%b, required 00a00513 104 1 0",
                         i, InstrF, PCF, InstrValidF, imem_req);
            end
        end
        @(negedge clock) StallF = 1'b0;
        wait_hs(10, ok, a);
        checks++;
        if (!ok || a !== 64'h108) begin
            errors++;
            $display("FAIL stall_next: ok=%b addr=%h, required 1 %h", ok, a, 64'h108);
        end
    endtask

    task automatic test_redirect_wait();
        bit          ok;
        bit          saw_valid;
        logic [63:0] a;
        ready_mode = 0; mem_lat = 3; mem_rand_lat = 1'b0;
        apply_reset();
        wait_hs(10, ok, a);
        @(negedge clock);
        PCSrcE    = 1'b1;
        PCTargetE = 64'h202;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_req: req=%b in wait, required 0", imem_req);
        end
        @(negedge clock) PCSrcE = 1'b0;
        saw_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            #1;
            if (InstrValidF) saw_valid = 1'b1;
            if (imem_req && imem_ready) begin
                ok = 1'b1;
                a  = imem_addr;
            end else begin
                @(negedge clock);
            end
        end
        checks++;
        if (!ok || saw_valid || a !== 64'h200) begin
            errors++;
            $display("FAIL redir_wait: ok=%b saw_valid=%b addr=%h, required 1 0 %h", ok, saw_valid, a, 64'h200);
        end
    endtask

    task automatic test_redirect_stall();
        bit ok;
        ready_mode = 0; mem_lat = 1; mem_rand_lat = 1'b0;
        apply_reset();
        StallF = 1'b1;
        wait_valid(10, ok);
        @(negedge clock);
        PCSrcE    = 1'b1;
        PCTargetE = 64'h400;
        @(negedge clock) PCSrcE = 1'b0;
        #1;
        checks++;
        if (!ok || InstrValidF !== 1'b0 || InstrF !== NOP || imem_req !== 1'b1 || imem_addr !== 64'h400) begin
            errors++;
            $display("FAIL redir_stall: ok=%b valid=%b InstrF=%h req=%b addr=%h, required 1 0 %h 1 %h",
                     ok, InstrValidF, InstrF, imem_req, imem_addr, NOP, 64'h400);
        end
        StallF = 1'b0;
    endtask

    task automatic test_ready_low();
        bit ok;
        ready_mode = 2; mem_lat = 1; mem_rand_lat = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RST_PC || InstrValidF !== 1'b0) begin
                errors++;
                $display("FAIL ready_low%0d: req=%b addr=%h valid=%b, required 1 %h 0",
                         i, imem_req, imem_addr, InstrValidF, RST_PC);
            end
            @(negedge clock);
        end
        PCSrcE    = 1'b1;
        PCTargetE = 64'h300;
        @(negedge clock);
        PCSrcE     = 1'b0;
        ready_mode = 0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h300) begin
            errors++;
            $display("FAIL ready_low_redir: req=%b addr=%h, required 1 %h", imem_req, imem_addr, 64'h300);
        end
        @(negedge clock);
        wait_valid(10, ok);
        checks++;
        if (!ok || PCF !== 64'h300) begin
            errors++;
            $display("FAIL ready_low_fetch: ok=%b PCF=%h, required 1 %h", ok, PCF, 64'h300);
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        logic [63:0] a;
        ready_mode = 0; mem_lat = 3; mem_rand_lat = 1'b0;
        apply_reset();
        wait_hs(10, ok, a);
        @(negedge clock);
        wait_hs(10, ok, a);
        checks++;
        if (!ok || a !== 64'h104) begin
            errors++;
            $display("FAIL rst_mid_pre: ok=%b addr=%h, required 1 %h", ok, a, 64'h104);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (InstrValidF !== 1'b0 || PCF !== RST_PC || InstrF !== NOP) begin
            errors++;
            $display("FAIL rst_mid: valid=%b PCF=%h InstrF=%h, required 0 %h %h", InstrValidF, PCF, InstrF, RST_PC, NOP);
        end
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
        wait_hs(10, ok, a);
        checks++;
        if (!ok || a !== RST_PC) begin
            errors++;
            $display("FAIL rst_mid_req: ok=%b addr=%h, required 1 %h", ok, a, RST_PC);
        end
        @(negedge clock);
        wait_valid(10, ok);
        checks++;
        if (!ok || PCF !== RST_PC || InstrF !== mem_word(RST_PC)) begin
            errors++;
            $display("FAIL rst_mid_fetch: ok=%b PCF=%h InstrF=%h, required 1 %h %h", ok, PCF, InstrF, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        logic [63:0] a;
        ready_mode = 0; mem_lat = 1; mem_rand_lat = 1'b0;
        apply_reset();
        PCSrcE    = 1'b1;
        PCTargetE = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clock) PCSrcE = 1'b0;
        wait_valid(12, ok);
        checks++;
        if (!ok || PCF !== 64'hFFFF_FFFF_FFFF_FFFC || PCPlus4F !== 64'h0) begin
            errors++;
            $display("FAIL wrap_valid: ok=%b PCF=%h PCPlus4F=%h, required 1 fffffffffffffffc 0", ok, PCF, PCPlus4F);
        end
        @(negedge clock);
        wait_hs(10, ok, a);
        checks++;
        if (!ok || a !== 64'h0) begin
            errors++;
            $display("FAIL wrap_next: ok=%b addr=%h, required 1 0", ok, a);
        end
    endtask

    task automatic test_random();
        int start_acc;
        ready_mode = 1; mem_rand_lat = 1'b1;
        apply_reset();
        start_acc = n_accept;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            StallF = ($urandom_range(0, 3) == 0);
            PCSrcE = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                PCTargetE = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom_range(0, 255))};
            else
                PCTargetE = {$urandom, $urandom};
        end
        @(negedge clock);
        StallF = 1'b0;
        PCSrcE = 1'b0;
        checks++;
        if (n_accept - start_acc < 50) begin
            errors++;
            $display("FAIL random_progress: %0d instructions accepted, required >= 50", n_accept - start_acc);
        end
        ready_mode = 0; mem_rand_lat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_ready_low();
        test_reset_mid();
        test_wrap();
        test_random();
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Pipeline fetch stage; drives InstrF, PCF and PCPlus4F into the decode stage.
- Owns the PC register and a single-outstanding request/response handshake to instruction memory.
- Buffers one fetched instruction until decode accepts it (InstrValidF high with StallF low).
- Honours the execute-stage redirect (PCSrcE/PCTargetE) by discarding any stale instruction or in-flight response.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, value driven on InstrF when no valid instruction is held (addi x0,x0,0).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  decode not accepting; hold the current instruction.
- PCSrcE  in  1  redirect request from execute.
- PCTargetE  in  64  redirect target.
- imem_req  out  1  instruction memory request.
- imem_addr  out  64  request address, {pc_q[63:2],2'b00}.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction word.
- InstrF  out  32  held instruction; NOP_INSTR when InstrValidF=0.
- PCF  out  64  pc_q.
- PCPlus4F  out  64  pc_q+4, modulo 2^64.
- InstrValidF  out  1  InstrF/PCF/PCPlus4F valid for decode.

Behaviour:
- Reset (reset=0, async): pc_q=RESET_PC; state=S_REQ; buffer=NOP_INSTR; imem_req=1 after reset release; InstrValidF=0; InstrF=NOP_INSTR. Reset mid-transaction abandons everything; instruction memory is reset on the same reset.
- Memory protocol: request accepted on a cycle with imem_req&imem_ready. Exactly one in-order response, imem_rvalid, no earlier than the following cycle. At most one request outstanding.
- PCTargetE[1:0] are cleared when loaded into pc_q.
- S_REQ: imem_req=1, imem_addr=pc_q.
  - PCSrcE=0, imem_ready=1: -> S_WAIT.
  - PCSrcE=1: pc_q<=PCTargetE. With imem_ready=1 -> S_DROP (stale request accepted); with imem_ready=0 stay in S_REQ (the new address is presented next cycle).
- S_WAIT: imem_req=0.
  - imem_rvalid=1, PCSrcE=0: buffer<=imem_rdata; -> S_VALID.
  - PCSrcE=1: pc_q<=PCTargetE. With imem_rvalid=1 discard the response and -> S_REQ; otherwise -> S_DROP.
- S_DROP: imem_req=0.
  - Wait for imem_rvalid, discard the data, -> S_REQ.
  - PCSrcE=1 here updates pc_q and stays consistent (same transition on rvalid).
- S_VALID: InstrValidF=1, InstrF=buffer. Priority: PCSrcE > StallF.
  - PCSrcE=1: pc_q<=PCTargetE, buffer<=NOP_INSTR, -> S_REQ.
  - StallF=0: pc_q<=pc_q+4, buffer<=NOP_INSTR, -> S_REQ (decode captures this cycle).
  - StallF=1: hold everything.
- Latency: request cycle -> response cycle (at least 1 later) -> InstrValidF the next cycle. Best case is one instruction every 3 cycles.
- StallF outside S_VALID has no effect on the FSM or pc_q.
- PC wrap: pc_q+4 wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0), no flag.
- imem_rvalid in S_REQ or S_VALID is a protocol violation; ignored, bench asserts it never occurs.

Decomposition:
- fetch_pkg: state enum (S_REQ, S_WAIT, S_VALID, S_DROP, 2-bit encoding), NOP_INSTR constant, default RESET_PC.
- One sub-module: fetch_fsm (next-state logic and control strobes: pc_load_target, pc_incr, buf_load, buf_clear, imem_req).
- PC and buffer registers and the adder stay in fetch_unit.

Test Plan:
- Reset RESET_PC=64'h100, imem_ready=1, memory latency 1, StallF=0 -> imem_addr sequence 0x100, 0x104, 0x108. Each word is presented with InstrValidF=1, PCF matching, PCPlus4F=PCF+4, once every 3 cycles.
- StallF=1 for 4 cycles while holding 32'h00A00513 at PCF=0x104 -> InstrF, PCF and InstrValidF stable, imem_req=0. After release, next address is 0x108.
- PCSrcE=1, PCTargetE=64'h202 while in S_WAIT, memory latency 3 -> response discarded, InstrValidF stays 0, next imem_addr=0x200.
- PCSrcE=1 and StallF=1 together in S_VALID with PCTargetE=0x400 -> buffer cleared to 0x00000013, next request at 0x400.
- imem_ready held 0 for 5 cycles -> imem_req=1 and imem_addr stable, InstrValidF=0. PCSrcE pulse during the wait changes imem_addr next cycle.
- reset asserted in S_WAIT -> immediately InstrValidF=0, PCF=RESET_PC, InstrF=0x00000013. After release, a fresh request at RESET_PC.
